// File: rtl/fp_pkg.sv
// Shared single-precision field widths, unpacked operand type and the
// compare/swap output bundle used by fp_compare_swap.
package fp_pkg;

  localparam int unsigned FP_W   = 32;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned MAN_W  = 24;
  localparam int unsigned MAG_W  = EXP_W + FRAC_W;

  localparam logic [FP_W-1:0] CANON_NAN = 32'h7FC00000;

  // Fraction is carried alongside the flushed mantissa so denormals still order correctly.
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
    logic [MAN_W-1:0]  man;
    logic              is_zero;
    logic              is_inf;
    logic              is_nan;
  } fp_unpacked_t;

  typedef struct packed {
    logic             comp;
    logic             a_sign;
    logic             b_sign;
    logic [EXP_W-1:0] big_exp;
    logic [EXP_W-1:0] small_exp;
    logic [MAN_W-1:0] big_man;
    logic [MAN_W-1:0] small_man;
  } cmp_bundle_t;

  function automatic logic [MAG_W-1:0] fp_mag(input fp_unpacked_t x);
    return {x.exp, x.frac};
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Combinational split of an IEEE-754 single into sign/exponent/mantissa
// with hidden bit and zero/inf/nan class flags; exponent 0 flushes the mantissa.
module fp_unpack
  import fp_pkg::*;
(
  input  logic [FP_W-1:0] value_i,
  output fp_unpacked_t    unp_o
);

  logic [EXP_W-1:0]  exp_c;
  logic [FRAC_W-1:0] frac_c;

  always_comb begin
    exp_c         = value_i[FP_W-2 -: EXP_W];
    frac_c        = value_i[FRAC_W-1:0];
    unp_o         = '0;
    unp_o.sign    = value_i[FP_W-1];
    unp_o.exp     = exp_c;
    unp_o.frac    = frac_c;
    unp_o.man     = (exp_c != '0) ? {1'b1, frac_c} : '0;
    unp_o.is_zero = (exp_c == '0) && (frac_c == '0);
    unp_o.is_inf  = (exp_c == '1) && (frac_c == '0);
    unp_o.is_nan  = (exp_c == '1) && (frac_c != '0);
  end

endmodule

// File: rtl/fp_compare_swap.sv
// Two-stage magnitude compare/swap of two singles ahead of a shift-add stage.
// Define FP_CMP_SPECIAL_EN to add the registered special/special_result outputs.
module fp_compare_swap
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  a_in,
  input  logic [FP_W-1:0]  b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             comp,
  output logic             a_sign,
  output logic             b_sign,
  output logic [EXP_W-1:0] big_exp,
  output logic [EXP_W-1:0] small_exp,
  output logic [MAN_W-1:0] big_man,
  output logic [MAN_W-1:0] small_man
`ifdef FP_CMP_SPECIAL_EN
  ,
  output logic             special,
  output logic [FP_W-1:0]  special_result
`endif
);

  fp_unpacked_t a_unp, b_unp;
  fp_unpacked_t a_q, a_d, b_q, b_d;
  logic         s1_valid_q, s1_valid_d;
  logic         s2_valid_q, s2_valid_d;
  cmp_bundle_t  bun_c, bun_q, bun_d;
  logic         s1_load_c, s2_load_c, comp_c;
  logic         unused_flags;

`ifdef FP_CMP_SPECIAL_EN
  logic            special_c, special_q, special_d;
  logic [FP_W-1:0] special_res_c, special_res_q, special_res_d;
`endif

  fp_unpack u_unpack_a (.value_i(a_in), .unp_o(a_unp));
  fp_unpack u_unpack_b (.value_i(b_in), .unp_o(b_unp));

  // Elastic handshake: a stage loads when empty or when its consumer moves.
  assign s2_load_c = !s2_valid_q || out_ready;
  assign s1_load_c = !s1_valid_q || s2_load_c;
  assign in_ready  = s1_load_c;

  always_comb begin
    comp_c         = fp_mag(a_q) >= fp_mag(b_q);
    bun_c          = '0;
    bun_c.comp     = comp_c;
    bun_c.a_sign   = a_q.sign;
    bun_c.b_sign   = b_q.sign;
    if (comp_c) begin
      bun_c.big_exp   = a_q.exp;
      bun_c.big_man   = a_q.man;
      bun_c.small_exp = b_q.exp;
      bun_c.small_man = b_q.man;
    end else begin
      bun_c.big_exp   = b_q.exp;
      bun_c.big_man   = b_q.man;
      bun_c.small_exp = a_q.exp;
      bun_c.small_man = a_q.man;
    end
  end

`ifdef FP_CMP_SPECIAL_EN
  // Any NaN or opposite-signed infinities yield the canonical NaN.
  always_comb begin
    special_c     = 1'b0;
    special_res_c = '0;
    if (a_q.is_nan || b_q.is_nan ||
        (a_q.is_inf && b_q.is_inf && (a_q.sign != b_q.sign))) begin
      special_c     = 1'b1;
      special_res_c = CANON_NAN;
    end else if (a_q.is_inf) begin
      special_c     = 1'b1;
      special_res_c = {a_q.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (b_q.is_inf) begin
      special_c     = 1'b1;
      special_res_c = {b_q.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end
  end
  assign unused_flags = ^{a_q.is_zero, b_q.is_zero};
`else
  assign unused_flags = ^{a_q.is_zero, b_q.is_zero, a_q.is_inf, b_q.is_inf,
                          a_q.is_nan, b_q.is_nan};
`endif

  always_comb begin
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    s2_valid_d = s2_valid_q;
    bun_d      = bun_q;
`ifdef FP_CMP_SPECIAL_EN
    special_d     = special_q;
    special_res_d = special_res_q;
`endif
    if (s1_load_c) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        a_d = a_unp;
        b_d = b_unp;
      end
    end
    if (s2_load_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        bun_d = bun_c;
`ifdef FP_CMP_SPECIAL_EN
        special_d     = special_c;
        special_res_d = special_res_c;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      s2_valid_q <= 1'b0;
      bun_q      <= '0;
`ifdef FP_CMP_SPECIAL_EN
      special_q     <= 1'b0;
      special_res_q <= '0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      s2_valid_q <= s2_valid_d;
      bun_q      <= bun_d;
`ifdef FP_CMP_SPECIAL_EN
      special_q     <= special_d;
      special_res_q <= special_res_d;
`endif
    end
  end

  assign out_valid = s2_valid_q;
  assign comp      = bun_q.comp;
  assign a_sign    = bun_q.a_sign;
  assign b_sign    = bun_q.b_sign;
  assign big_exp   = bun_q.big_exp;
  assign small_exp = bun_q.small_exp;
  assign big_man   = bun_q.big_man;
  assign small_man = bun_q.small_man;
`ifdef FP_CMP_SPECIAL_EN
  assign special        = special_q;
  assign special_result = special_res_q;
`endif

endmodule

// File: doc/fp_compare_swap.md
FP_COMPARE_SWAP -- requirements
Module: fp_compare_swap

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port in_valid, input, 1: operand pair on a_in/b_in valid.
REQ-004 SHALL have port in_ready, output, 1: block accepts a pair this cycle.
REQ-005 SHALL have ports a_in and b_in, input, 32 each: IEEE-754 single-precision operands A, B.
REQ-006 SHALL have port out_valid, output, 1: output bundle valid.
REQ-007 SHALL have port out_ready, input, 1: downstream shift-add stage consumes bundle.
REQ-008 SHALL have port comp, output, 1: 1 = |A| >= |B| (A is big operand).
REQ-009 SHALL have ports a_sign and b_sign, output, 1 each: original operand signs.
REQ-010 SHALL have ports big_exp and small_exp, output, 8 each: biased exponents of larger and smaller magnitude.
REQ-011 SHALL have ports big_man and small_man, output, 24 each: {hidden bit, fraction} of larger and smaller magnitude.

Function
REQ-012 SHALL be a 2-stage pipeline: S1 registers unpacked operands; S2 registers compare/swap result; latency 2 cycles accept-to-out_valid; throughput 1 pair/cycle.
REQ-013 SHALL accept a pair when in_valid && in_ready; bundle transfers when out_valid && out_ready.
REQ-014 SHALL let S2 load when S2 empty or out_ready=1, and S1 load when S1 empty or S2 loads; in_ready = S1 load condition (combinational, no dependence on in_valid).
REQ-015 SHALL hold all S2 outputs stable while out_valid=1 and out_ready=0.
REQ-016 SHALL never drop, duplicate or reorder pairs.
REQ-017 SHALL set hidden bit = 1 when exponent != 0; exponent 0 (zero/denormal) flushes mantissa to 24'h0.
REQ-018 SHALL compare magnitudes as unsigned 31-bit {exp, frac}; equal magnitudes give comp=1.
REQ-019 SHALL route A to big_* when comp=1, else B; other operand to small_*.
REQ-020 SHALL guarantee big_exp >= small_exp on every valid output.

Reset
REQ-021 SHALL on rst_n=0 immediately clear S1/S2 valid flags: out_valid=0, in_ready=1, comp=0, signs=0, exps=8'h00, mans=24'h0.
REQ-022 SHALL discard in-flight pairs when reset asserts mid-operation; first accept possible on first clock edge after deassertion.

Configuration
REQ-023 SHALL, with macro FP_CMP_SPECIAL_EN defined, add outputs special (1) and special_result (32) registered in S2 alongside the bundle.
REQ-024 SHALL, with FP_CMP_SPECIAL_EN: any NaN or +Inf plus -Inf -> special=1, special_result=32'h7FC00000; else one Inf -> special=1, result = that Inf; else special=0, result=32'h0.
REQ-025 SHALL, without FP_CMP_SPECIAL_EN, omit both ports and all special-case logic; Inf/NaN pass through as ordinary exponent-255 values.

Structure
REQ-026 SHALL take EXP_W=8, FRAC_W=23, MAN_W=24, canonical NaN 32'h7FC00000 and the unpacked-operand typedef (sign, exp, man, is_zero, is_inf, is_nan) from shared package fp_pkg.
REQ-027 SHALL instantiate sub-module fp_unpack twice (A, B): combinational field split, hidden bit, class flags.

Verification
REQ-028 SHALL test A=32'h40400000, B=32'h3F800000 -> 2 cycles later comp=1, big_exp=8'h80, small_exp=8'h7F, big_man=24'hC00000, small_man=24'h800000.
REQ-029 SHALL test A=32'h3F800000, B=32'hC0400000 -> comp=0, a_sign=0, b_sign=1, big_exp=8'h80, big_man=24'hC00000.
REQ-030 SHALL test A=32'h40000000, B=32'hC0000000 -> comp=1, big_exp=small_exp=8'h80; A=32'h00000001 -> man 24'h0.
REQ-031 SHALL test 4 back-to-back pairs with out_ready=0 for 5 cycles -> in_ready=0 after 2 accepts, outputs held, all 4 delivered in order once out_ready=1.
REQ-032 SHALL test rst_n pulsed low with 2 pairs in flight -> out_valid=0 asynchronously, no stale bundle after release.
REQ-033 SHALL test, with FP_CMP_SPECIAL_EN, A=32'h7F800000, B=32'hFF800000 -> special=1, special_result=32'h7FC00000; A=32'h7F800000, B=32'h3F800000 -> special_result=32'h7F800000.
